// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states and default frame geometry,
// used by both the frame receiver and the frame-streaming transmitter.
package spi_pkg;

  localparam int SPI_ADDR_WIDTH  = 14;
  localparam int SPI_FRAME_WORDS = 10240;
  localparam int SPI_WORD_BITS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } spi_rx_state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Frame buffer write port: the receiver drives it (master), the buffer sinks it (slave).
interface spi_frame_rx_if #(
  parameter int ADDR_WIDTH = 14
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/spi_frame_rx_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous inputs into the clk domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 master frame receiver: clocks in FRAME_WORDS 16-bit MSB-first words
// and writes each one into the frame buffer at its word index.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = SPI_ADDR_WIDTH,
  parameter int FRAME_WORDS = SPI_FRAME_WORDS,
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           spi_sck,
  output logic           spi_ncs,
  input  logic           spi_miso,
  spi_frame_rx_if.master wr
);

  localparam logic [15:0]           DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0]           CS_LAST   = 16'(CS_SETUP - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

  spi_rx_state_t         state;
  logic [15:0]           cnt;
  logic [3:0]            bit_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [15:0]           shift;
  logic                  last_bit;
  logic                  miso_s;

  sync2 #(.WIDTH(1)) u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d   (spi_miso),
    .q   (miso_s)
  );

  // Abort outranks everything outside IDLE; in IDLE it only blocks a same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shift      <= '0;
      last_bit   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      spi_sck    <= 1'b0;
      spi_ncs    <= 1'b1;
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      wr.wr_en <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        spi_ncs <= 1'b1;
        spi_sck <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state    <= ST_SETUP;
              cnt      <= '0;
              bit_cnt  <= '0;
              word_cnt <= '0;
              shift    <= '0;
              last_bit <= 1'b0;
              spi_ncs  <= 1'b0;
              spi_sck  <= 1'b0;
              busy     <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (cnt == CS_LAST) begin
              cnt   <= '0;
              state <= ST_LOW;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_LOW: begin
            if (cnt == DIV_LAST) begin
              cnt     <= '0;
              spi_sck <= 1'b1;
              state   <= ST_HIGH;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_HIGH: begin
            // Sample once per bit, on the first cycle with SCK high.
            if (cnt == 16'd0) begin
              shift   <= {shift[14:0], miso_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                wr.wr_en   <= 1'b1;
                wr.wr_data <= {shift[14:0], miso_s};
                wr.wr_addr <= word_cnt;
                if (word_cnt == LAST_WORD) begin
                  last_bit <= 1'b1;
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end
            end
            if (cnt == DIV_LAST) begin
              cnt     <= '0;
              spi_sck <= 1'b0;
              state   <= last_bit ? ST_HOLD : ST_LOW;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_HOLD: begin
            if (cnt == CS_LAST) begin
              cnt     <= '0;
              state   <= ST_IDLE;
              spi_ncs <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            spi_ncs <= 1'b1;
            spi_sck <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx with a behavioural mode-0 SPI slave
// (FRAME_WORDS=4, CLK_DIV=4, CS_SETUP=8).
module tb_spi_frame_rx;

  localparam int AW = 14;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic spi_miso = 1'b0;
  logic busy, done, aborted, spi_sck, spi_ncs;

  spi_frame_rx_if #(.ADDR_WIDTH(AW)) wr_bus ();

  spi_frame_rx #(
    .ADDR_WIDTH  (AW),
    .FRAME_WORDS (FW),
    .CLK_DIV     (4),
    .CS_SETUP    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .spi_sck  (spi_sck),
    .spi_ncs  (spi_ncs),
    .spi_miso (spi_miso),
    .wr       (wr_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sck_rises = 0;
  int ncs_low = 0;
  int busy_cycles = 0;
  int done_cnt = 0;
  int aborted_cnt = 0;
  int wr_cnt = 0;
  logic mon_sck_prev = 1'b0;
  logic mon_ncs_prev = 1'b1;
  logic [29:0] exp_q[$];
  logic [15:0] tx_words[FW];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Slave: presents word 0 bit 15 while deselected, then shifts about 2.5 cycles after each SCK rise.
  int slave_bit = 0;
  int slave_dly = 0;
  logic slave_sck_prev = 1'b0;
  always @(negedge clk) begin
    if (spi_ncs) begin
      slave_bit = 0;
      slave_dly = 0;
      spi_miso = tx_words[0][15];
    end else if (spi_sck && !slave_sck_prev) begin
      slave_dly = 2;
    end else if (slave_dly != 0) begin
      slave_dly--;
      if (slave_dly == 0) begin
        slave_bit++;
        if (slave_bit < FW * 16) spi_miso = tx_words[slave_bit / 16][15 - (slave_bit % 16)];
      end
    end
    slave_sck_prev = spi_sck;
  end

  // Monitor: counts bus events and checks every write against the scoreboard queue.
  always @(negedge clk) begin
    logic [29:0] e;
    if (spi_sck && !mon_sck_prev) sck_rises++;
    if (!spi_ncs) ncs_low++;
    if (busy) busy_cycles++;
    if (aborted) aborted_cnt++;
    if (done) begin
      done_cnt++;
      checkOutput("done_at_ncs_rise", {30'd0, mon_ncs_prev, spi_ncs}, 32'd1);
    end
    if (wr_bus.wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 wr_bus.wr_addr, wr_bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(wr_bus.wr_addr), 32'(e[29:16]));
        checkOutput("wr_data", 32'(wr_bus.wr_data), 32'(e[15:0]));
      end
    end
    mon_sck_prev = spi_sck;
    mon_ncs_prev = spi_ncs;
  end

  task automatic clearCounters();
    sck_rises = 0;
    ncs_low = 0;
    busy_cycles = 0;
    done_cnt = 0;
    aborted_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic pushFrame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({14'(i), tx_words[i]});
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: got busy after 3000 cycles, expected idle", name);
    end
  endtask

  task automatic waitRises(input int target, input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (sck_rises >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: got %0d SCK rises, expected %0d", name, sck_rises, target);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ncs"}, 32'(spi_ncs), 32'd1);
    checkOutput({tag, "_sck"}, 32'(spi_sck), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_aborted"}, 32'(aborted), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_bus.wr_en), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_bus.wr_data), 32'd0);
  endtask

  initial begin
    tx_words[0] = 16'hA55A;
    tx_words[1] = 16'h0001;
    tx_words[2] = 16'h8000;
    tx_words[3] = 16'hFFFF;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full frame.
    $display("[TB] full frame");
    clearCounters();
    pushFrame(FW);
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_ncs", 32'(spi_ncs), 32'd0);
    waitIdle("full_frame_timeout");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_wr_count", 32'(wr_cnt), 32'd4);
    checkOutput("full_sck_rises", 32'(sck_rises), 32'd64);
    checkOutput("full_ncs_low", 32'(ncs_low), 32'd528);
    checkOutput("full_done_count", 32'(done_cnt), 32'd1);
    checkOutput("full_aborted_count", 32'(aborted_cnt), 32'd0);
    checkOutput("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort after word 1 plus 5 bits of word 2.
    $display("[TB] abort mid-frame");
    clearCounters();
    pushFrame(2);
    applyStimulus(1'b1, 1'b0);
    waitRises(37, "abort_rise_timeout");
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_ncs", 32'(spi_ncs), 32'd1);
    checkOutput("abort_sck", 32'(spi_sck), 32'd0);
    checkOutput("abort_pulse", 32'(aborted), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort_wr_count", 32'(wr_cnt), 32'd2);
    checkOutput("abort_done_count", 32'(done_cnt), 32'd0);
    checkOutput("abort_aborted_count", 32'(aborted_cnt), 32'd1);
    checkOutput("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored.
    $display("[TB] start while busy");
    clearCounters();
    pushFrame(FW);
    applyStimulus(1'b1, 1'b0);
    waitRises(20, "busy_start_rise_timeout");
    applyStimulus(1'b1, 1'b0);
    waitIdle("busy_start_timeout");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_start_wr_count", 32'(wr_cnt), 32'd4);
    checkOutput("busy_start_ncs_low", 32'(ncs_low), 32'd528);
    checkOutput("busy_start_done_count", 32'(done_cnt), 32'd1);
    checkOutput("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

    // start and abort together in IDLE: nothing happens.
    $display("[TB] start with abort in idle");
    clearCounters();
    applyStimulus(1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_sa_ncs_low", 32'(ncs_low), 32'd0);
    checkOutput("idle_sa_busy_cycles", 32'(busy_cycles), 32'd0);
    checkOutput("idle_sa_done_count", 32'(done_cnt), 32'd0);
    checkOutput("idle_sa_aborted_count", 32'(aborted_cnt), 32'd0);

    // Reset during word 2, then a clean frame with new data.
    $display("[TB] reset mid-frame");
    clearCounters();
    pushFrame(2);
    applyStimulus(1'b1, 1'b0);
    waitRises(40, "rst_rise_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("midrst");
    rst = 1'b0;
    checkOutput("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    tx_words[0] = 16'h1234;
    tx_words[1] = 16'h5678;
    tx_words[2] = 16'h9ABC;
    tx_words[3] = 16'hDEF0;
    @(posedge clk);
    #1;
    clearCounters();
    pushFrame(FW);
    applyStimulus(1'b1, 1'b0);
    waitIdle("post_rst_timeout");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_wr_count", 32'(wr_cnt), 32'd4);
    checkOutput("post_rst_done_count", 32'(done_cnt), 32'd1);
    checkOutput("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
